// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// fetch_entry_t is one instruction-queue entry: fetch PC, instruction word and
// the fetch-error flag. ENTRY_W is its packed width, which the queue uses for its
// flat ports.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned ENTRY_W     = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue of fetch_entry_t.
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset (clears all storage)
//   push_i         write wdata_i at the tail
//   pop_i          drop the head entry
//   flush_i        empty the queue; takes priority over push and pop
//   wdata_i        entry to write
//   head_o         entry at the head, taken straight from storage
//   count_o        number of occupied entries
// DEPTH must be a power of two so that the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = fetch_entry_t'(wdata_i);
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (!(pop_i && count_q == '0));
            assert (!(push_i && !pop_i && count_q == DEPTH_C));
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational program
// memory, and queues {pc, instr, err} entries for decode.
// Ports:
//   clk_i, rst_ni     clock and synchronous active-low reset
//   pc_o              registered fetch address to program memory
//   mem_data_i        instruction word for pc_o (same cycle)
//   redirect_i        single-cycle redirect request; flushes the queue
//   redirect_pc_i     redirect target
//   instr_valid_o     head entry valid
//   instr_ready_i     decode accepts the head
//   instr_o           head instruction (NOP when fetch_err_o)
//   instr_pc_o        head PC
//   fetch_err_o       head fetched out of range (or misaligned)
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned redirect target is kept
// unmasked and the first entry fetched from it is flagged as an error.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_BYTES  = 128,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] pc_o,
    input  logic [31:0] mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_err_o
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      target;
    logic             bad_align;
    logic             push, pop, err;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wentry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // Sticky until the flagged entry is pushed or another redirect arrives.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_i) begin
            misalign_d = |redirect_pc_i[1:0];
        end else if (push) begin
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign target    = redirect_pc_i;
    assign bad_align = misalign_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc_i[1:0];
    assign target    = {redirect_pc_i[31:2], 2'b00};
    assign bad_align = 1'b0;
`endif

    assign instr_valid_o = (count != '0);
    assign pop  = instr_valid_o & instr_ready_i;
    // A pop frees its slot in the same cycle, so a full queue can still push.
    assign push = !redirect_i & ((count < DEPTH_C) | pop);
    assign err  = (pc_q > LAST_PC) | bad_align;

    always_comb begin
        wentry.pc    = pc_q;
        wentry.instr = err ? NOP_INSTR : mem_data_i;
        wentry.err   = err;
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target;
        end else if (push) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (wentry),
        .head_o  (head),
        .count_o (count)
    );

    assign pc_o        = pc_q;
    assign instr_o     = head.instr;
    assign instr_pc_o  = head.pc;
    assign fetch_err_o = head.err;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The reference model is a queue of
// expected entries plus an expected PC, advanced once per clock from the
// fetch rules (push when there is room or a pop, redirect flushes).
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam int unsigned T_MEM      = 128;
    localparam int unsigned T_DEPTH    = 2;
    localparam logic [31:0] T_LAST     = 32'd124;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] mem_data_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fetch_err_o;

    logic [31:0] mem [32];

    fetch_entry_t m_q[$];
    logic [31:0]  m_pc;
    bit           m_mis;
    int           checks = 0;
    int           errors = 0;

    always #5 clk_i = ~clk_i;

    assign mem_data_i = (pc_o < 32'(T_MEM)) ? mem[pc_o[6:2]] : 32'hDEAD_BEEF;

    instr_fetch #(
        .RESET_PC   (T_RESET_PC),
        .MEM_BYTES  (T_MEM),
        .FIFO_DEPTH (T_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_o          (pc_o),
        .mem_data_i    (mem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .fetch_err_o   (fetch_err_o)
    );

    // Drive one cycle of inputs, advance the model across the edge, then
    // return #1 after the edge where outputs are sampled.
    task automatic drive(input bit rst, input bit rdy, input bit redir, input logic [31:0] tgt);
        fetch_entry_t e;
        bit pop;
        rst_ni        = rst;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        if (!rst) begin
            m_q.delete();
            m_pc  = T_RESET_PC;
            m_mis = 0;
        end else if (redir) begin
            m_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc  = tgt;
            m_mis = (tgt[1:0] != 2'b00);
`else
            m_pc  = tgt & ~32'd3;
            m_mis = 0;
`endif
        end else begin
            pop = (m_q.size() != 0) && rdy;
            if (m_q.size() < T_DEPTH || pop) begin
                e.pc    = m_pc;
                e.err   = (m_pc > T_LAST) || m_mis;
                e.instr = e.err ? NOP_INSTR : mem[m_pc[6:2]];
                m_q.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_mis = 0;
            end
            if (pop) void'(m_q.pop_front());
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset(input string tag);
        drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        drive(0, 1, 0, '0);
        checks++;
        if (instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL %s_valid got %b exp 0", tag, instr_valid_o);
        end
        checks++;
        if (instr_o !== 32'h0 || instr_pc_o !== 32'h0 || fetch_err_o !== 1'b0) begin
            errors++; $display("FAIL %s_head got %h/%h/%b exp 0/0/0", tag, instr_o, instr_pc_o, fetch_err_o);
        end
        checks++;
        if (pc_o !== T_RESET_PC) begin
            errors++; $display("FAIL %s_pc got %h exp %h", tag, pc_o, T_RESET_PC);
        end
    endtask

    task automatic test_stream();
        drive(1, 1, 0, '0);
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'h0050_0093) begin
            errors++; $display("FAIL stream_first got v%b pc %h ins %h exp v1 pc 0 ins 00500093",
                               instr_valid_o, instr_pc_o, instr_o);
        end
        for (int i = 1; i < 20; i++) begin
            drive(1, 1, 0, '0);
            checks++;
            if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(i * 4) || instr_o !== mem[i]) begin
                errors++; $display("FAIL stream_walk cyc %0d got v%b pc %h ins %h exp pc %h ins %h",
                                   i, instr_valid_o, instr_pc_o, instr_o, 32'(i * 4), mem[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen[$];
        test_reset("bp_reset");
        for (int i = 0; i < 5; i++) drive(1, 0, 0, '0);
        checks++;
        if (pc_o !== 32'h8 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== mem[0]) begin
            errors++; $display("FAIL bp_stall got pc_o %h v%b head %h exp pc_o 8 v1 head 0",
                               pc_o, instr_valid_o, instr_pc_o);
        end
        for (int i = 0; i < 6; i++) begin
            if (instr_valid_o === 1'b1) seen.push_back(instr_pc_o);
            drive(1, 1, 0, '0);
        end
        checks++;
        if (seen.size() < 3 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
            errors++; $display("FAIL bp_order got %0d pcs first %h %h %h exp 0 4 8",
                               seen.size(), seen.size() > 0 ? seen[0] : 32'hx,
                               seen.size() > 1 ? seen[1] : 32'hx, seen.size() > 2 ? seen[2] : 32'hx);
        end
    endtask

    task automatic test_redirect_full();
        test_reset("rf_reset");
        for (int i = 0; i < 3; i++) drive(1, 0, 0, '0);
        drive(1, 0, 1, 32'h40);
        checks++;
        if (instr_valid_o !== 1'b0 || pc_o !== 32'h40) begin
            errors++; $display("FAIL rf_flush got v%b pc_o %h exp v0 pc_o 40", instr_valid_o, pc_o);
        end
        drive(1, 1, 0, '0);
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40 || instr_o !== mem[16]) begin
            errors++; $display("FAIL rf_target got v%b pc %h ins %h exp v1 pc 40 ins %h",
                               instr_valid_o, instr_pc_o, instr_o, mem[16]);
        end
    endtask

    task automatic test_end_of_mem();
        drive(1, 1, 1, 32'h78);
        drive(1, 1, 0, '0);
        drive(1, 1, 0, '0);
        checks++;
        if (instr_pc_o !== 32'h7C || fetch_err_o !== 1'b0 || instr_o !== mem[31]) begin
            errors++; $display("FAIL eom_last got pc %h err %b ins %h exp pc 7c err 0 ins %h",
                               instr_pc_o, fetch_err_o, instr_o, mem[31]);
        end
        drive(1, 1, 0, '0);
        checks++;
        if (instr_pc_o !== 32'h80 || fetch_err_o !== 1'b1 || instr_o !== NOP_INSTR) begin
            errors++; $display("FAIL eom_past got pc %h err %b ins %h exp pc 80 err 1 ins 00000013",
                               instr_pc_o, fetch_err_o, instr_o);
        end
        // PC wrap across 2^32 back into the valid range.
        drive(1, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, '0);
            checks++;
            if (instr_valid_o !== 1'b1 || {instr_pc_o, instr_o, fetch_err_o} !== m_q[0]) begin
                errors++; $display("FAIL eom_wrap cyc %0d got %h/%h/%b exp %h", i,
                                   instr_pc_o, instr_o, fetch_err_o, m_q[0]);
            end
        end
    endtask

    task automatic test_redirect_pop();
        drive(1, 0, 1, 32'h10);
        drive(1, 0, 0, '0);
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h10) begin
            errors++; $display("FAIL rp_setup got v%b pc %h exp v1 pc 10", instr_valid_o, instr_pc_o);
        end
        drive(1, 1, 1, 32'h30);
        checks++;
        if (instr_valid_o !== 1'b0 || pc_o !== 32'h30) begin
            errors++; $display("FAIL rp_flush got v%b pc_o %h exp v0 pc_o 30", instr_valid_o, pc_o);
        end
        drive(1, 0, 0, '0);
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h30) begin
            errors++; $display("FAIL rp_target got v%b pc %h exp v1 pc 30", instr_valid_o, instr_pc_o);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc, exp_ins;
        logic        exp_err;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_pc = 32'h22; exp_err = 1'b1; exp_ins = NOP_INSTR;
`else
        exp_pc = 32'h20; exp_err = 1'b0; exp_ins = mem[8];
`endif
        drive(1, 0, 1, 32'h22);
        drive(1, 0, 0, '0);
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || fetch_err_o !== exp_err || instr_o !== exp_ins) begin
            errors++; $display("FAIL misalign got v%b pc %h err %b ins %h exp pc %h err %b ins %h",
                               instr_valid_o, instr_pc_o, fetch_err_o, instr_o, exp_pc, exp_err, exp_ins);
        end
        drive(1, 1, 0, '0);
        checks++;
        if (instr_pc_o !== exp_pc + 32'd4 || fetch_err_o !== 1'b0) begin
            errors++; $display("FAIL misalign_next got pc %h err %b exp pc %h err 0",
                               instr_pc_o, fetch_err_o, exp_pc + 32'd4);
        end
    endtask

    task automatic test_random();
        bit          rst, redir;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) != 0);
            redir = ($urandom_range(0, 11) == 0);
            tgt   = 32'($urandom_range(0, 40) * 4 + $urandom_range(0, 3));
            drive(rst, $urandom_range(0, 2) != 0, redir, tgt);
            checks++;
            if (instr_valid_o !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, instr_valid_o, m_q.size() != 0);
            end
            checks++;
            if (pc_o !== m_pc) begin
                errors++; $display("FAIL rand_pc cyc %0d got %h exp %h", i, pc_o, m_pc);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({instr_pc_o, instr_o, fetch_err_o} !== m_q[0]) begin
                    errors++; $display("FAIL rand_head cyc %0d got %h/%h/%b exp %h", i,
                                       instr_pc_o, instr_o, fetch_err_o, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h00F0_0193;
        for (int i = 3; i < 32; i++) mem[i] = $urandom;
        test_reset("reset");
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_end_of_mem();
        test_redirect_pop();
        test_misalign();
        test_random();
        drive(1, 0, 0, '0);
        drive(1, 0, 0, '0);
        test_reset("reset_midop");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
